// File: rtl/batch_issuer_pkg.sv
// Shared types and constants for the batch issuer: FSM states, payload slot
// layout and the result value reported for a timed-out item.
package batch_issuer_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE     = 3'd1,
      WAIT_DONE = 3'd2,
      RESULT    = 3'd3,
      FINISH    = 3'd4
   } state_t;

   // Each item occupies three consecutive ITEM_WIDTH slots: op, A, B
   localparam int unsigned SLOT_OP        = 0;
   localparam int unsigned SLOT_A         = 1;
   localparam int unsigned SLOT_B         = 2;
   localparam int unsigned SLOTS_PER_ITEM = 3;

   // Timed-out items report all ones; truncated to the result width at use
   localparam int unsigned        ERR_FILL_W = 64;
   localparam logic [ERR_FILL_W-1:0] ERR_FILL = '1;

endpackage

// File: rtl/batch_item_select.sv
// Combinational extractor: returns the op/A/B fields of item idx from the
// packed batch payload (slot 0 in the LSBs).
module batch_item_select
   import batch_issuer_pkg::*;
#(
   parameter int unsigned MAX_ITEMS  = 100,
   parameter int unsigned ITEM_WIDTH = 8,
   parameter int unsigned OP_W       = 3,
   parameter int unsigned CNT_W      = $clog2(MAX_ITEMS + 1)
) (
   input  logic [MAX_ITEMS*SLOTS_PER_ITEM*ITEM_WIDTH-1:0] payload,
   input  logic [CNT_W-1:0]                               idx,
   output logic [OP_W-1:0]                                op_c,
   output logic [ITEM_WIDTH-1:0]                          a_c,
   output logic [ITEM_WIDTH-1:0]                          b_c
);

   localparam int unsigned N_SLOTS = MAX_ITEMS * SLOTS_PER_ITEM;
   localparam int unsigned SEL_W   = $clog2(N_SLOTS);

   logic [ITEM_WIDTH-1:0] slot [N_SLOTS];
   logic [SEL_W-1:0]      base;

   for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
      assign slot[g] = payload[g*ITEM_WIDTH +: ITEM_WIDTH];
   end

   // Opcode comes from the low OP_W bits of the op slot
   always_comb begin
      base = SEL_W'(idx) * SEL_W'(SLOTS_PER_ITEM);
      op_c = OP_W'(slot[base + SEL_W'(SLOT_OP)]);
      a_c  = slot[base + SEL_W'(SLOT_A)];
      b_c  = slot[base + SEL_W'(SLOT_B)];
   end

endmodule

// File: rtl/batch_issuer.sv
// Accepts a packed batch of (op, A, B) items and issues them one at a time
// over start/done, returning each result on a back-pressured indexed stream.
module batch_issuer
   import batch_issuer_pkg::*;
#(
   parameter int unsigned MAX_ITEMS  = 100,
   parameter int unsigned ITEM_WIDTH = 8,
   parameter int unsigned OP_W       = 3,
   parameter int unsigned RES_W      = 16,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned CNT_W      = $clog2(MAX_ITEMS + 1)
) (
   input  logic                                         clk_i,
   input  logic                                         reset_i,
   input  logic                                         batch_valid_i,
   output logic                                         batch_ready_o,
   input  logic [CNT_W-1:0]                             batch_len_i,
   input  logic [MAX_ITEMS*SLOTS_PER_ITEM*ITEM_WIDTH-1:0] batch_data_i,
   output logic [OP_W-1:0]                              op_o,
   output logic [ITEM_WIDTH-1:0]                        A_o,
   output logic [ITEM_WIDTH-1:0]                        B_o,
   output logic                                         start_o,
   input  logic                                         done_i,
   input  logic [RES_W-1:0]                             res_i,
   output logic                                         res_valid_o,
   input  logic                                         res_ready_i,
   output logic [RES_W-1:0]                             res_data_o,
   output logic [CNT_W-1:0]                             res_index_o,
   output logic                                         res_err_o,
   output logic                                         batch_done_o,
   output logic                                         busy_o
);

   localparam int unsigned PAY_W = MAX_ITEMS * SLOTS_PER_ITEM * ITEM_WIDTH;
   localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   state_t             state_q, state_n;
   logic [PAY_W-1:0]   payload_q, payload_n;
   logic [CNT_W-1:0]   len_q, len_n;
   logic [CNT_W-1:0]   idx_q, idx_n;
   logic [TMR_W-1:0]   tmr_q, tmr_n;
   logic               capture;
   logic               timeout;
   logic [OP_W-1:0]    sel_op;
   logic [ITEM_WIDTH-1:0] sel_a, sel_b;

   // Operands are selected from the next-cycle payload/index so the
   // registered op/A/B are valid in the same cycle as start_o.
   batch_item_select #(
      .MAX_ITEMS  (MAX_ITEMS),
      .ITEM_WIDTH (ITEM_WIDTH),
      .OP_W       (OP_W),
      .CNT_W      (CNT_W)
   ) u_select (
      .payload (payload_n),
      .idx     (idx_n),
      .op_c    (sel_op),
      .a_c     (sel_a),
      .b_c     (sel_b)
   );

   // State register and per-batch bookkeeping
   always_ff @(posedge clk_i or negedge reset_i) begin : p_state
      if (!reset_i) begin
         state_q   <= IDLE;
         payload_q <= '0;
         len_q     <= '0;
         idx_q     <= '0;
         tmr_q     <= '0;
      end else begin
         state_q   <= state_n;
         payload_q <= payload_n;
         len_q     <= len_n;
         idx_q     <= idx_n;
         tmr_q     <= tmr_n;
      end
   end

   // Next-state logic
   always_comb begin : p_next
      state_n   = state_q;
      payload_n = payload_q;
      len_n     = len_q;
      idx_n     = idx_q;
      tmr_n     = tmr_q;
      capture   = 1'b0;
      timeout   = 1'b0;

      case (state_q)
         IDLE: begin
            if (batch_valid_i) begin
               payload_n = batch_data_i;
               len_n     = (batch_len_i > CNT_W'(MAX_ITEMS)) ? CNT_W'(MAX_ITEMS)
                                                             : batch_len_i;
               idx_n     = '0;
               state_n   = (batch_len_i == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE: begin
            tmr_n   = '0;
            state_n = WAIT_DONE;
         end
         WAIT_DONE: begin
            tmr_n = tmr_q + TMR_W'(1);
            // done_i wins over a coincident timeout
            if (done_i) begin
               capture = 1'b1;
               state_n = RESULT;
            end else if (tmr_q == TMR_W'(TIMEOUT - 2)) begin
               timeout = 1'b1;
               state_n = RESULT;
            end
         end
         RESULT: begin
            if (res_ready_i) begin
               if (idx_q == len_q - CNT_W'(1)) begin
                  state_n = FINISH;
               end else begin
                  idx_n   = idx_q + CNT_W'(1);
                  state_n = ISSUE;
               end
            end
         end
         FINISH: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Registered outputs, decoded from the next state
   always_ff @(posedge clk_i or negedge reset_i) begin : p_out
      if (!reset_i) begin
         batch_ready_o <= 1'b1;
         busy_o        <= 1'b0;
         start_o       <= 1'b0;
         res_valid_o   <= 1'b0;
         batch_done_o  <= 1'b0;
         op_o          <= '0;
         A_o           <= '0;
         B_o           <= '0;
         res_data_o    <= '0;
         res_index_o   <= '0;
         res_err_o     <= 1'b0;
      end else begin
         batch_ready_o <= (state_n == IDLE);
         busy_o        <= (state_n != IDLE);
         start_o       <= (state_n == ISSUE);
         res_valid_o   <= (state_n == RESULT);
         batch_done_o  <= (state_n == FINISH);
         if (state_n == ISSUE) begin
            op_o <= sel_op;
            A_o  <= sel_a;
            B_o  <= sel_b;
         end
         if (capture) begin
            res_data_o  <= res_i;
            res_err_o   <= 1'b0;
            res_index_o <= idx_q;
         end else if (timeout) begin
            res_data_o  <= RES_W'(ERR_FILL);
            res_err_o   <= 1'b1;
            res_index_o <= idx_q;
         end
      end
   end

endmodule

// File: tb/tb_batch_issuer.sv
// Directed bench for batch_issuer: a small ALU responder answers start_o with
// res = {A,B} ^ op after a programmable latency; expected values are hand-computed.
module tb_batch_issuer;

   localparam int unsigned MAX_ITEMS  = 100;
   localparam int unsigned ITEM_WIDTH = 8;
   localparam int unsigned OP_W       = 3;
   localparam int unsigned RES_W      = 16;
   localparam int unsigned TIMEOUT    = 8;
   localparam int unsigned CNT_W      = 7;
   localparam int unsigned PAY_W      = MAX_ITEMS * 3 * ITEM_WIDTH;

   logic                  clk_i = 1'b0;
   logic                  reset_i;
   logic                  batch_valid_i;
   logic                  batch_ready_o;
   logic [CNT_W-1:0]      batch_len_i;
   logic [PAY_W-1:0]      batch_data_i;
   logic [OP_W-1:0]       op_o;
   logic [ITEM_WIDTH-1:0] A_o, B_o;
   logic                  start_o;
   logic                  done_i;
   logic [RES_W-1:0]      res_i;
   logic                  res_valid_o;
   logic                  res_ready_i;
   logic [RES_W-1:0]      res_data_o;
   logic [CNT_W-1:0]      res_index_o;
   logic                  res_err_o;
   logic                  batch_done_o;
   logic                  busy_o;

   int n_cmp = 0;
   int n_bad = 0;
   int n_start = 0;
   int n_bdone = 0;

   // Responder controls
   int          resp_lat = 2;
   logic        skip_en = 1'b0;
   logic [7:0]  skip_a = 8'h00;
   logic        spur_done = 1'b0;
   logic        resp_done;
   logic        armed;
   int          cnt;
   logic [15:0] resp_res;

   assign done_i = resp_done | spur_done;
   assign res_i  = spur_done ? 16'hDEAD : resp_res;

   batch_issuer #(
      .MAX_ITEMS  (MAX_ITEMS),
      .ITEM_WIDTH (ITEM_WIDTH),
      .OP_W       (OP_W),
      .RES_W      (RES_W),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_i         (clk_i),
      .reset_i       (reset_i),
      .batch_valid_i (batch_valid_i),
      .batch_ready_o (batch_ready_o),
      .batch_len_i   (batch_len_i),
      .batch_data_i  (batch_data_i),
      .op_o          (op_o),
      .A_o           (A_o),
      .B_o           (B_o),
      .start_o       (start_o),
      .done_i        (done_i),
      .res_i         (res_i),
      .res_valid_o   (res_valid_o),
      .res_ready_i   (res_ready_i),
      .res_data_o    (res_data_o),
      .res_index_o   (res_index_o),
      .res_err_o     (res_err_o),
      .batch_done_o  (batch_done_o),
      .busy_o        (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // ALU responder: done_i pulses resp_lat cycles after start_o
   always @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         resp_done <= 1'b0;
         armed     <= 1'b0;
         cnt       <= 0;
         resp_res  <= '0;
      end else begin
         resp_done <= 1'b0;
         if (armed) begin
            if (cnt <= 1) begin
               resp_done <= 1'b1;
               armed     <= 1'b0;
            end else begin
               cnt <= cnt - 1;
            end
         end
         if (start_o && !(skip_en && A_o == skip_a)) begin
            resp_res <= {A_o, B_o} ^ {13'd0, op_o};
            if (resp_lat <= 1) begin
               resp_done <= 1'b1;
            end else begin
               armed <= 1'b1;
               cnt   <= resp_lat - 1;
            end
         end
      end
   end

   always @(posedge clk_i) begin
      if (start_o)      n_start <= n_start + 1;
      if (batch_done_o) n_bdone <= n_bdone + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_item(input int k, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] b);
      batch_data_i[(3*k)*8 +: 8]   = op;
      batch_data_i[(3*k+1)*8 +: 8] = a;
      batch_data_i[(3*k+2)*8 +: 8] = b;
   endtask

   // Offer a batch for one cycle; returns at the negedge after the accept edge
   task automatic offer(input logic [CNT_W-1:0] len);
      batch_valid_i = 1'b1;
      batch_len_i   = len;
      tick();
      batch_valid_i = 1'b0;
   endtask

   task automatic chk_issue(input string tag, input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b);
      chk({tag, "_start"}, start_o, 1);
      chk({tag, "_op"}, op_o, op);
      chk({tag, "_a"}, A_o, a);
      chk({tag, "_b"}, B_o, b);
   endtask

   task automatic chk_res(input string tag, input int idx, input logic [15:0] data,
                          input logic err);
      chk({tag, "_valid"}, res_valid_o, 1);
      chk({tag, "_index"}, res_index_o, idx);
      chk({tag, "_data"}, res_data_o, data);
      chk({tag, "_err"}, res_err_o, err);
   endtask

   initial begin
      int s0, b0, nres, last_idx;
      logic [15:0] last_data;
      bit got_done;

      reset_i       = 1'b0;
      batch_valid_i = 1'b0;
      batch_len_i   = '0;
      batch_data_i  = '0;
      res_ready_i   = 1'b0;
      tick(2);

      // Reset state
      chk("rst_ready", batch_ready_o, 1);
      chk("rst_busy", busy_o, 0);
      chk("rst_start", start_o, 0);
      chk("rst_valid", res_valid_o, 0);
      chk("rst_bdone", batch_done_o, 0);
      chk("rst_data", res_data_o, 0);
      chk("rst_op", op_o, 0);
      reset_i = 1'b1;
      tick();

      // Basic batch of three, DUT latency 2, consumer always ready
      set_item(0, 8'd1, 8'h05, 8'h03);
      set_item(1, 8'd2, 8'h10, 8'h02);
      set_item(2, 8'd7, 8'hFF, 8'h01);
      res_ready_i = 1'b1;
      s0 = n_start;
      b0 = n_bdone;
      offer(3);
      chk_issue("b_i0", 8'd1, 8'h05, 8'h03);
      chk("b_ready_low", batch_ready_o, 0);
      chk("b_busy", busy_o, 1);
      tick(2);
      chk("b_no_early_res", res_valid_o, 0);
      tick();
      chk_res("b_r0", 0, 16'h0502, 1'b0);
      tick();
      chk_issue("b_i1", 8'd2, 8'h10, 8'h02);
      chk("b_valid_drop", res_valid_o, 0);
      tick(3);
      chk_res("b_r1", 1, 16'h1000, 1'b0);
      tick();
      chk_issue("b_i2", 8'd7, 8'hFF, 8'h01);
      tick(3);
      chk_res("b_r2", 2, 16'hFF06, 1'b0);
      tick();
      chk("b_bdone", batch_done_o, 1);
      chk("b_ready_finish", batch_ready_o, 0);
      tick();
      chk("b_bdone_pulse", batch_done_o, 0);
      chk("b_ready_again", batch_ready_o, 1);
      chk("b_idle", busy_o, 0);
      chk("b_nstart", n_start - s0, 3);
      chk("b_nbdone", n_bdone - b0, 1);

      // Back-pressure on item 0
      batch_data_i = '0;
      set_item(0, 8'd3, 8'h20, 8'h04);
      set_item(1, 8'd4, 8'h11, 8'h22);
      res_ready_i = 1'b0;
      offer(2);
      chk_issue("bp_i0", 8'd3, 8'h20, 8'h04);
      tick(3);
      for (int i = 0; i < 5; i++) begin
         chk_res("bp_hold", 0, 16'h2007, 1'b0);
         chk("bp_no_start", start_o, 0);
         if (i == 4) res_ready_i = 1'b1;
         tick();
      end
      chk_issue("bp_i1", 8'd4, 8'h11, 8'h22);
      chk("bp_valid_drop", res_valid_o, 0);
      tick(3);
      chk_res("bp_r1", 1, 16'h1126, 1'b0);
      tick();
      chk("bp_bdone", batch_done_o, 1);
      tick();

      // Timeout on item 1 of 3
      batch_data_i = '0;
      set_item(0, 8'd5, 8'h01, 8'h02);
      set_item(1, 8'd6, 8'hAA, 8'h55);
      set_item(2, 8'd0, 8'h7E, 8'h81);
      skip_en = 1'b1;
      skip_a  = 8'hAA;
      b0 = n_bdone;
      offer(3);
      chk_issue("to_i0", 8'd5, 8'h01, 8'h02);
      tick(3);
      chk_res("to_r0", 0, 16'h0107, 1'b0);
      tick();
      chk_issue("to_i1", 8'd6, 8'hAA, 8'h55);
      tick(7);
      chk("to_not_yet", res_valid_o, 0);
      tick();
      chk_res("to_r1", 1, 16'hFFFF, 1'b1);
      tick();
      chk_issue("to_i2", 8'd0, 8'h7E, 8'h81);
      tick(3);
      chk_res("to_r2", 2, 16'h7E81, 1'b0);
      tick();
      chk("to_bdone", batch_done_o, 1);
      tick();
      chk("to_nbdone", n_bdone - b0, 1);
      skip_en = 1'b0;

      // Zero-length batch: straight to FINISH, no start
      s0 = n_start;
      offer(0);
      chk("z_bdone", batch_done_o, 1);
      chk("z_start", start_o, 0);
      chk("z_busy", busy_o, 1);
      tick();
      chk("z_bdone_pulse", batch_done_o, 0);
      chk("z_ready", batch_ready_o, 1);
      chk("z_nstart", n_start - s0, 0);

      // Over-length batch (127 > MAX_ITEMS) clamps to 100 items
      batch_data_i = '0;
      for (int k = 0; k < 100; k++)
         set_item(k, 8'(k), 8'(k), 8'(k + 1));
      resp_lat  = 1;
      nres      = 0;
      last_idx  = -1;
      last_data = '0;
      got_done  = 1'b0;
      offer(7'd127);
      for (int c = 0; c < 600 && !got_done; c++) begin
         if (res_valid_o) begin
            chk("ol_index", res_index_o, nres);
            last_idx  = int'(res_index_o);
            last_data = res_data_o;
            nres++;
         end
         if (batch_done_o) got_done = 1'b1;
         else tick();
      end
      chk("ol_done_seen", got_done, 1);
      chk("ol_count", nres, 100);
      chk("ol_last_idx", last_idx, 99);
      chk("ol_last_data", last_data, 16'h6367);
      tick();

      // Asynchronous reset during WAIT_DONE of item 4
      batch_data_i = '0;
      for (int k = 0; k < 6; k++)
         set_item(k, 8'(k + 1), 8'(8'h30 + k), 8'(8'h40 + k));
      resp_lat = 2;
      b0 = n_bdone;
      offer(6);
      tick(16);
      chk_issue("rs_i4", 8'd5, 8'h34, 8'h44);
      tick();
      chk("rs_wait_busy", busy_o, 1);
      chk("rs_prev_index", res_index_o, 3);
      #1 reset_i = 1'b0;
      #1;
      chk("rs_ready", batch_ready_o, 1);
      chk("rs_busy", busy_o, 0);
      chk("rs_start", start_o, 0);
      chk("rs_valid", res_valid_o, 0);
      chk("rs_data", res_data_o, 0);
      chk("rs_index", res_index_o, 0);
      chk("rs_op", op_o, 0);
      chk("rs_a", A_o, 0);
      chk("rs_b", B_o, 0);
      chk("rs_bdone", batch_done_o, 0);
      tick();
      reset_i = 1'b1;
      tick(3);
      chk("rs_no_bdone", n_bdone - b0, 0);
      chk("rs_idle", busy_o, 0);
      batch_data_i = '0;
      set_item(0, 8'd1, 8'h02, 8'h03);
      offer(1);
      chk_issue("rs_fresh_i0", 8'd1, 8'h02, 8'h03);
      tick(3);
      chk_res("rs_fresh_r0", 0, 16'h0202, 1'b0);
      tick();
      chk("rs_fresh_bdone", batch_done_o, 1);
      tick();

      // Spurious done in IDLE, RESULT and ISSUE; batch offered while busy
      spur_done = 1'b1;
      tick(2);
      chk("sp_idle_busy", busy_o, 0);
      chk("sp_idle_valid", res_valid_o, 0);
      chk("sp_idle_ready", batch_ready_o, 1);
      spur_done = 1'b0;
      batch_data_i = '0;
      set_item(0, 8'd2, 8'h0A, 8'h0B);
      set_item(1, 8'd3, 8'h0C, 8'h0D);
      res_ready_i = 1'b0;
      s0 = n_start;
      offer(2);
      chk_issue("sp_i0", 8'd2, 8'h0A, 8'h0B);
      tick(3);
      chk_res("sp_r0", 0, 16'h0A09, 1'b0);
      spur_done     = 1'b1;
      batch_valid_i = 1'b1;
      batch_len_i   = 7'd5;
      set_item(1, 8'd6, 8'h66, 8'h77);
      tick();
      chk_res("sp_r0_hold", 0, 16'h0A09, 1'b0);
      chk("sp_busy_ready", batch_ready_o, 0);
      chk("sp_no_start", start_o, 0);
      spur_done = 1'b0;
      tick();
      chk_res("sp_r0_hold2", 0, 16'h0A09, 1'b0);
      batch_valid_i = 1'b0;
      res_ready_i   = 1'b1;
      tick();
      chk_issue("sp_i1", 8'd3, 8'h0C, 8'h0D);
      spur_done = 1'b1;
      tick();
      spur_done = 1'b0;
      chk("sp_issue_done_ignored", res_valid_o, 0);
      tick();
      chk("sp_wait", res_valid_o, 0);
      tick();
      chk_res("sp_r1", 1, 16'h0C0E, 1'b0);
      tick();
      chk("sp_bdone", batch_done_o, 1);
      tick(4);
      chk("sp_nstart", n_start - s0, 2);
      chk("sp_final_idle", busy_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
